spi_ram_burst: RTL

Parametrised command-decoded RAM slave behind the SPI slave shift logic; successor to the fixed 256x8 SPI RAM. Width and depth are generic, read and write address pointers are independent, and optional auto-increment gives burst access. Sits between the SPI slave deserialiser (`din`/`rx_valid`) and its serialiser (`dout`/`tx_valid`).

---
 rtl/spi_ram_pkg.sv | 11 +
 rtl/spi_ram_burst_if.sv | 25 ++
 rtl/spi_ram_array.sv | 27 ++
 rtl/spi_ram_burst.sv | 99 +++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encoding for the burst-capable SPI RAM slave.
package spi_ram_pkg;

    typedef logic [1:0] spi_cmd_t;

    localparam spi_cmd_t CMD_SET_WADDR = 2'b00;
    localparam spi_cmd_t CMD_WRITE     = 2'b01;
    localparam spi_cmd_t CMD_SET_RADDR = 2'b10;
    localparam spi_cmd_t CMD_READ      = 2'b11;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Link between the SPI slave shift logic and the RAM command decoder.
interface spi_ram_burst_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();

    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wrap;

    modport master (
        output din, rx_valid,
        input  dout, tx_valid, wr_ptr, rd_ptr, wrap
    );

    modport slave (
        input  din, rx_valid,
        output dout, tx_valid, wr_ptr, rd_ptr, wrap
    );

endinterface

// File: rtl/spi_ram_array.sv
// Simple dual-port storage: one synchronous write port, one registered read port.
module spi_ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Left unreset so synthesis maps it onto block RAM; o_rdata is the read stage register.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/spi_ram_burst.sv
// Command-decoded RAM slave with independent write/read pointers and optional burst increment.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    spi_ram_burst_if.slave bus
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

    spi_cmd_t          w_cmd;
    logic [DATA_W-1:0] w_payload;
    logic [ADDR_W-1:0] w_addr;
    logic              w_we;
    logic              w_re;
    logic [DATA_W-1:0] w_rd_data;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_wrap;
    logic              r_rd_pend;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_dout;

    assign w_cmd     = spi_cmd_t'(bus.din[DATA_W+1:DATA_W]);
    assign w_payload = bus.din[DATA_W-1:0];
    assign w_addr    = w_payload[ADDR_W-1:0];
    assign w_we      = bus.rx_valid && (w_cmd == CMD_WRITE);
    assign w_re      = bus.rx_valid && (w_cmd == CMD_READ);

    spi_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_payload),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wrap     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_dout     <= '0;
        end else begin
            r_wrap <= 1'b0;

            // Stage 1 -> stage 2: array output is presented one edge after the READ.
            r_rd_pend  <= w_re;
            r_tx_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_dout <= w_rd_data;
            end

            if (bus.rx_valid) begin
                case (w_cmd)
                    CMD_SET_WADDR: r_wr_ptr <= w_addr;
                    CMD_WRITE: begin
                        if (AUTO_INC) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_wr_ptr == MAX_ADDR) begin
                                r_wrap <= 1'b1;
                            end
                        end
                    end
                    CMD_SET_RADDR: r_rd_ptr <= w_addr;
                    CMD_READ: begin
                        if (AUTO_INC) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                            if (r_rd_ptr == MAX_ADDR) begin
                                r_wrap <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.tx_valid = r_tx_valid;
    assign bus.wr_ptr   = r_wr_ptr;
    assign bus.rd_ptr   = r_rd_ptr;
    assign bus.wrap     = r_wrap;

endmodule
